// File: rtl/crack.sv
// crack: brute-force ARC4 key search over a 24-bit key space.
// For each candidate key the block runs KSA and PRGA on an internal S array.
// It accepts the first key whose decrypted bytes of the length-prefixed
// ciphertext are all printable ASCII (0x20..0x7E).
module crack (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic        rdy,
   output logic [23:0] key,
   output logic        key_valid,
   output logic [7:0]  ct_addr,
   input  logic [7:0]  ct_rddata
);

   typedef enum logic [3:0] {
      IDLE, INIT, KSA_RD, KSA_ACC, KSA_SWP, LEN_W, LEN_R,
      P_RD, P_ACC, P_SWP, P_PAD, P_CHK, NEXT, DONE
   } state_t;

   state_t      state_q, state_d;
   logic [23:0] key_attempt, key_attempt_d;
   logic [23:0] key_q, key_d;
   logic        kv_q, kv_d;
   logic [7:0]  addr_q, addr_d;
   logic [7:0]  i_q, i_d, j_q, j_d;
   logic [1:0]  m_q, m_d;          // i mod 3, tracked incrementally
   logic [7:0]  tmp_q, tmp_d;      // S[i] captured during KSA
   logic [7:0]  len_q, len_d;
   logic [7:0]  k_q, k_d;          // message byte index 1..L
   logic [7:0]  pad_q, pad_d;
   logic [7:0]  s_q [256];

   logic [7:0]  kb, pidx, pt;
   logic        pt_ok;

   assign rdy       = (state_q == IDLE);
   assign key       = key_q;
   assign key_valid = kv_q;
   assign ct_addr   = addr_q;

   // key byte for the current KSA step, selected by i mod 3
   always_comb begin
      case (m_q)
         2'd0:    kb = key_attempt[23:16];
         2'd1:    kb = key_attempt[15:8];
         default: kb = key_attempt[7:0];
      endcase
   end

   // next-state and datapath updates for the whole search
   always_comb begin
      state_d       = state_q;
      key_attempt_d = key_attempt;
      key_d         = key_q;
      kv_d          = kv_q;
      addr_d        = addr_q;
      i_d           = i_q;
      j_d           = j_q;
      m_d           = m_q;
      tmp_d         = tmp_q;
      len_d         = len_q;
      k_d           = k_q;
      pad_d         = pad_q;
      pidx          = s_q[i_q] + s_q[j_q];
      pt            = pad_q ^ ct_rddata;
      // unknown data makes this condition non-true, so it falls into rejection
      pt_ok         = (pt >= 8'h20) && (pt <= 8'h7E);
      case (state_q)
         IDLE: begin
            if (en) begin
               key_attempt_d = 24'd0;
               kv_d          = 1'b0;
               i_d           = 8'd0;
               state_d       = INIT;
            end
         end
         INIT: begin
            i_d = i_q + 8'd1;
            if (i_q == 8'hFF) begin
               j_d     = 8'd0;
               m_d     = 2'd0;
               state_d = KSA_RD;
            end
         end
         KSA_RD: begin
            tmp_d   = s_q[i_q];
            state_d = KSA_ACC;
         end
         KSA_ACC: begin
            j_d     = j_q + tmp_q + kb;
            state_d = KSA_SWP;
         end
         KSA_SWP: begin
            i_d = i_q + 8'd1;
            m_d = (m_q == 2'd2) ? 2'd0 : m_q + 2'd1;
            if (i_q == 8'hFF) begin
               addr_d  = 8'd0;
               state_d = LEN_W;
            end else begin
               state_d = KSA_RD;
            end
         end
         // RAM samples ct_addr at the end of LEN_W; data is stable in LEN_R
         LEN_W: state_d = LEN_R;
         LEN_R: begin
            len_d = ct_rddata;
            i_d   = 8'd0;
            j_d   = 8'd0;
            k_d   = 8'd1;
            if (ct_rddata == 8'd0) begin
               key_d   = key_attempt;
               kv_d    = 1'b1;
               state_d = DONE;
            end else begin
               state_d = P_RD;
            end
         end
         P_RD: begin
            // launch the ct[k] fetch early; it settles before P_CHK
            i_d     = i_q + 8'd1;
            addr_d  = k_q;
            state_d = P_ACC;
         end
         P_ACC: begin
            j_d     = j_q + s_q[i_q];
            state_d = P_SWP;
         end
         P_SWP: state_d = P_PAD;
         P_PAD: begin
            pad_d   = s_q[pidx];
            state_d = P_CHK;
         end
         P_CHK: begin
            if (pt_ok) begin
               if (k_q == len_q) begin
                  key_d   = key_attempt;
                  kv_d    = 1'b1;
                  state_d = DONE;
               end else begin
                  k_d     = k_q + 8'd1;
                  state_d = P_RD;
               end
            end else begin
               state_d = NEXT;
            end
         end
         NEXT: begin
            if (key_attempt == 24'hFFFFFF) begin
               kv_d    = 1'b0;
               state_d = DONE;
            end else begin
               key_attempt_d = key_attempt + 24'd1;
               i_d           = 8'd0;
               state_d       = INIT;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // control and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         key_attempt <= 24'd0;
         key_q       <= 24'd0;
         kv_q        <= 1'b0;
         addr_q      <= 8'd0;
         i_q         <= 8'd0;
         j_q         <= 8'd0;
         m_q         <= 2'd0;
         tmp_q       <= 8'd0;
         len_q       <= 8'd0;
         k_q         <= 8'd0;
         pad_q       <= 8'd0;
      end else begin
         state_q     <= state_d;
         key_attempt <= key_attempt_d;
         key_q       <= key_d;
         kv_q        <= kv_d;
         addr_q      <= addr_d;
         i_q         <= i_d;
         j_q         <= j_d;
         m_q         <= m_d;
         tmp_q       <= tmp_d;
         len_q       <= len_d;
         k_q         <= k_d;
         pad_q       <= pad_d;
      end
   end

   // S array: identity fill, then swaps; fully rewritten each attempt so no reset
   always_ff @(posedge clk) begin
      case (state_q)
         INIT: s_q[i_q] <= i_q;
         KSA_SWP: begin
            s_q[i_q] <= s_q[j_q];
            s_q[j_q] <= tmp_q;
         end
         P_SWP: begin
            s_q[i_q] <= s_q[j_q];
            s_q[j_q] <= s_q[i_q];
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_crack.sv
// Bench for crack: synchronous ciphertext RAM model, ARC4 reference model,
// and directed steps with randomized messages.
module tb_crack;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        rdy;
   logic [23:0] key;
   logic        key_valid;
   logic [7:0]  ct_addr;
   logic [7:0]  ct_rddata = 8'd0;

   logic [7:0]  mem   [256];
   logic [7:0]  pad_m [256];
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // synchronous-read ciphertext memory
   always @(posedge clk) ct_rddata <= mem[ct_addr];

   crack dut (
      .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key),
      .key_valid(key_valid), .ct_addr(ct_addr), .ct_rddata(ct_rddata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // reference ARC4: fills pad_m[1..n] with the keystream for key k
   function automatic void gen_pads(input logic [23:0] k, input int n);
      int s [256];
      int j, t, a, b;
      for (int x = 0; x < 256; x++) s[x] = x;
      j = 0;
      for (int x = 0; x < 256; x++) begin
         j = (j + s[x] + int'((k >> (8 * (2 - (x % 3)))) & 24'hFF)) % 256;
         t = s[x]; s[x] = s[j]; s[j] = t;
      end
      a = 0; b = 0;
      for (int x = 1; x <= n; x++) begin
         a = (a + 1) % 256;
         b = (b + s[a]) % 256;
         t = s[a]; s[a] = s[b]; s[b] = t;
         pad_m[x] = 8'(s[(s[a] + s[b]) % 256]);
      end
   endfunction

   function automatic bit model_ok(input logic [23:0] k);
      int l;
      logic [7:0] p;
      l = int'(mem[0]);
      gen_pads(k, l);
      for (int x = 1; x <= l; x++) begin
         p = pad_m[x] ^ mem[x];
         if (p < 8'h20 || p > 8'h7E) return 1'b0;
      end
      return 1'b1;
   endfunction

   // lowest key that the search should stop on; lim itself always passes
   function automatic logic [23:0] first_key(input logic [23:0] lim);
      for (int k = 0; k < int'(lim); k++)
         if (model_ok(24'(k))) return 24'(k);
      return lim;
   endfunction

   // encrypt a random printable message of length l with key k
   function automatic void load_ct(input logic [23:0] k, input int l);
      for (int x = 0; x < 256; x++) mem[x] = 8'($urandom);
      mem[0] = 8'(l);
      gen_pads(k, l);
      for (int x = 1; x <= l; x++) mem[x] = 8'($urandom_range(32, 126)) ^ pad_m[x];
   endfunction

   task automatic start();
      @(negedge clk); en = 1'b1;
      @(negedge clk); en = 1'b0;
   endtask

   task automatic wait_rdy(input int budget, input string tag);
      int n = 0;
      while (!rdy && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, {31'd0, rdy}, 32'd1);
   endtask

   logic [23:0] exp_key, prev_key;
   int          ln;
   int          guard;

   initial begin
      for (int x = 0; x < 256; x++) mem[x] = 8'd0;

      // reset state, both during and after reset
      repeat (3) @(negedge clk);
      check("rst_rdy", {31'd0, rdy}, 32'd1);
      check("rst_kv", {31'd0, key_valid}, 32'd0);
      check("rst_key", {8'd0, key}, 32'd0);
      check("rst_addr", {24'd0, ct_addr}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_rdy", {31'd0, rdy}, 32'd1);
      check("idle_kv", {31'd0, key_valid}, 32'd0);
      check("idle_key", {8'd0, key}, 32'd0);

      // L=0 succeeds immediately on key 0
      mem[0] = 8'd0;
      start();
      check("busy_rdy", {31'd0, rdy}, 32'd0);
      check("start_ka", {8'd0, dut.key_attempt}, 32'd0);
      wait_rdy(3000, "l0_done");
      check("l0_kv", {31'd0, key_valid}, 32'd1);
      check("l0_key", {8'd0, key}, 32'd0);

      // en held high while busy must not restart the search
      load_ct(24'h000002, 12);
      exp_key = first_key(24'h000002);
      @(negedge clk); en = 1'b1;
      repeat (1200) @(negedge clk);
      check("hold_rdy", {31'd0, rdy}, 32'd0);
      check("hold_ka", {8'd0, dut.key_attempt}, 32'd1);
      en = 1'b0;
      wait_rdy(6000, "hold_done");
      check("hold_kv", {31'd0, key_valid}, 32'd1);
      check("hold_key", {8'd0, key}, {8'd0, exp_key});

      // main case: key 0x000018, printable message of 20 bytes
      load_ct(24'h000018, 20);
      exp_key = first_key(24'h000018);
      start();
      wait_rdy(40000, "k18_done");
      check("k18_kv", {31'd0, key_valid}, 32'd1);
      check("k18_key", {8'd0, key}, 32'h18);
      check("k18_model", {8'd0, key}, {8'd0, exp_key});

      // randomized short messages with small keys
      for (int r = 0; r < 2; r++) begin
         ln = int'($urandom_range(1, 30));
         load_ct(24'($urandom_range(0, 3)), ln);
         exp_key = first_key(24'h000003);
         start();
         wait_rdy(6000, "rnd_done");
         check("rnd_kv", {31'd0, key_valid}, 32'd1);
         check("rnd_key", {8'd0, key}, {8'd0, exp_key});
      end

      // exhaustion: jump to the last key with a rejecting ciphertext
      prev_key = key;
      for (int x = 0; x < 256; x++) mem[x] = 8'($urandom);
      mem[0] = 8'd255;
      mem[1] = 8'h00;
      start();
      repeat (100) @(negedge clk);
      force dut.key_attempt = 24'hFFFFFF;
      @(negedge clk);
      release dut.key_attempt;
      wait_rdy(34000, "exh_done");
      check("exh_kv", {31'd0, key_valid}, 32'd0);
      check("exh_key", {8'd0, key}, {8'd0, prev_key});
      check("exh_ka", {8'd0, dut.key_attempt}, 32'hFFFFFF);

      // reset mid-PRGA, then restart from key 0
      load_ct(24'h000003, 20);
      start();
      guard = 0;
      while (ct_addr == 8'd0 && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      check("prga_seen", {31'd0, ct_addr != 8'd0}, 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rdy", {31'd0, rdy}, 32'd1);
      check("mid_kv", {31'd0, key_valid}, 32'd0);
      check("mid_key", {8'd0, key}, 32'd0);
      check("mid_addr", {24'd0, ct_addr}, 32'd0);
      check("mid_ka", {8'd0, dut.key_attempt}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      load_ct(24'h000003, 20);
      exp_key = first_key(24'h000003);
      start();
      check("re_ka", {8'd0, dut.key_attempt}, 32'd0);
      wait_rdy(6000, "re_done");
      check("re_kv", {31'd0, key_valid}, 32'd1);
      check("re_key", {8'd0, key}, {8'd0, exp_key});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/crack.md
CRACK -- requirements
Module: crack

Interface
REQ-001 clk  input  1  sole clock; all state changes on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 en  input  1  start request; sampled only while rdy=1.
REQ-004 rdy  output  1  high = idle, able to accept en.
REQ-005 key  output  24  recovered key; valid only when key_valid=1.
REQ-006 key_valid  output  1  high = last run found a key.
REQ-007 ct_addr  output  8  address into external ciphertext memory.
REQ-008 ct_rddata  input  8  ciphertext memory read data; synchronous RAM, data for ct_addr valid one cycle after the address is driven.

Function
REQ-009 Ciphertext format SHALL be length-prefixed: ct[0] = L (0..255); message bytes are ct[1..L].
REQ-010 The block SHALL hold a 24-bit internal register named key_attempt holding the key under test; benches access it hierarchically, so it SHALL be a single plain register, not renamed, split or duplicated.
REQ-011 On en=1 with rdy=1 at a clock edge: key_attempt<=0, key_valid<=0, rdy<=0 on that same edge; en while rdy=0 SHALL be ignored.
REQ-012 Per attempt, the block SHALL run ARC4 on an internal 256x8 state array S: init S[i]=i; KSA j=0, for i=0..255: j=(j+S[i]+kb[i mod 3]) mod 256, swap S[i],S[j]; kb[0]=key_attempt[23:16], kb[1]=[15:8], kb[2]=[7:0].
REQ-013 PRGA SHALL run with i=j=0, for k=1..L: i=i+1, j=j+S[i], swap, pad=S[(S[i]+S[j]) mod 256], pt=pad XOR ct[k]; all sums mod 256.
REQ-014 An attempt SHALL succeed when every pt byte lies in 0x20..0x7E inclusive; any byte outside that range, including unknown/X data, SHALL be a rejection.
REQ-015 The block SHALL abort an attempt at the first rejected byte and start the next attempt.
REQ-016 L=0 SHALL count as immediate success.
REQ-017 On success: key<=key_attempt, key_valid<=1, rdy<=1.
REQ-018 On rejection: if key_attempt==24'hFFFFFF (compared on the live register at rejection time), then key_valid<=0, key unchanged, rdy<=1; otherwise key_attempt<=key_attempt+1 and the next attempt starts.
REQ-019 A full attempt with L=255 SHALL complete in at most 30000 clock cycles.
REQ-020 key and key_valid SHALL hold their values while idle until the next accepted en.
REQ-021 States: IDLE, INIT, KSA (read/accumulate/swap sub-steps), LEN (fetch ct[0]), PRGA (read/swap/pad/ct fetch/check sub-steps), NEXT, DONE->IDLE.
REQ-022 ct_addr SHALL be the only access to ciphertext; the block SHALL never write it.

Reset
REQ-023 rst_n=0 SHALL asynchronously force rdy=1, key_valid=0, key=0, ct_addr=0, key_attempt=0 and state IDLE, including mid-run.
REQ-024 After rst_n rises, the block SHALL be idle with rdy=1 before any en.

Verification
REQ-025 Reset then release -> rdy=1, key_valid=0, key=0 before en.
REQ-026 en pulse one cycle while rdy=1 -> rdy=0 at the next sample; en held while busy -> no restart.
REQ-027 Start, then after ~100 cycles force key_attempt=24'hFFFFFF with ciphertext that rejects -> within 34000 cycles rdy=1, key_valid=0.
REQ-028 Ciphertext encrypted by a model with key 24'h000018 (printable message, L=20) -> rdy=1, key_valid=1, key=24'h000018.
REQ-029 ct[0]=0 -> success on the first attempt, key=24'h000000, key_valid=1.
REQ-030 Assert rst_n mid-PRGA -> outputs return to reset values immediately; a new en restarts from key 0.
